// File: rtl/cnnout_reader.sv
// Read side of the 8-channel CNN output bank: sweeps every channel/address after a layer
// and re-emits the words as a tagged valid/ready byte stream through a credit-limited skid FIFO.
module cnnout_reader #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  output logic              rd_en,
  output logic [5:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic [5:0]        m_ch,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        ch;
  logic [ADDR_W-1:0] nw_q;

  logic              tag_v    [RD_LAT];
  logic [5:0]        tag_ch   [RD_LAT];
  logic              tag_last [RD_LAT];
  logic [5:0]        sel_q;

  logic [DATA_W-1:0] f_data [FIFO_D];
  logic [5:0]        f_ch   [FIFO_D];
  logic              f_last [FIFO_D];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     f_count;

  logic [CW-1:0]     inflight;
  logic              credit;
  logic              issue;
  logic              issue_last;
  logic              push;
  logic              pop;
  logic              drained;
  logic              accept;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_v[i]);
  end

  // Reads already in the tag pipe hold a FIFO slot, so the FIFO can never overflow.
  assign credit     = ({1'b0, f_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_D);
  assign issue      = (state == S_READ) && credit;
  assign issue_last = (ch == 6'(NUM_CH - 1)) && (addr == nw_q - 1'b1);
  assign push       = tag_v[RD_LAT-1];
  assign pop        = m_valid && m_ready;
  assign drained    = (inflight == '0) && (f_count == CW'(pop));
  assign accept     = (state == S_IDLE) && start;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign rd_en   = busy;
  assign rd_addr = addr;
  assign rd_sel  = push ? tag_ch[RD_LAT-1] : sel_q;

  assign m_valid = (f_count != '0);
  assign m_data  = f_data[rd_ptr];
  assign m_ch    = f_ch[rd_ptr];
  assign m_last  = f_last[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= (num_words == '0) ? S_DONE : S_READ;
        S_READ:  if (issue && issue_last) state <= S_DRAIN;
        S_DRAIN: if (drained) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      addr <= '0;
      ch   <= '0;
      nw_q <= '0;
    end else if (accept) begin
      addr <= '0;
      ch   <= '0;
      nw_q <= num_words;
    end else if (issue) begin
      if (addr == nw_q - 1'b1) begin
        addr <= '0;
        if (!issue_last) ch <= ch + 6'd1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  // Tag pipe mirrors the bank read latency so channel/last line up with returning data.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v[i]    <= 1'b0;
        tag_ch[i]   <= '0;
        tag_last[i] <= 1'b0;
      end
      sel_q <= '0;
    end else begin
      tag_v[0]    <= issue;
      tag_ch[0]   <= ch;
      tag_last[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_ch[i]   <= tag_ch[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      if (push) sel_q <= tag_ch[RD_LAT-1];
    end
  end

  // NOTE: the FIFO storage is a handful of flops, so it is reset too; that keeps m_* at zero out of reset.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < FIFO_D; i++) begin
        f_data[i] <= '0;
        f_ch[i]   <= '0;
        f_last[i] <= 1'b0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      f_count <= '0;
    end else begin
      if (push) begin
        f_data[wr_ptr] <= rd_data;
        f_ch[wr_ptr]   <= tag_ch[RD_LAT-1];
        f_last[wr_ptr] <= tag_last[RD_LAT-1];
        wr_ptr         <= (wr_ptr == PW'(FIFO_D - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_D - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   f_count <= f_count + 1'b1;
        2'b01:   f_count <= f_count - 1'b1;
        default: f_count <= f_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (global_rst)
    !(push && !pop && (f_count == CW'(FIFO_D))));

endmodule
